// File: rtl/rggen_bus_arbiter_if.sv
// rggen_bus_if: register-block bus bundle shared by bus bridges and the
// register block.
//   valid/address/write/write_data/strobe : master -> slave request
//   ready/status/read_data                : slave -> master response
// status encoding: 2'b00 OKAY, 2'b01 EXOKAY, 2'b10 SLAVE_ERROR,
// 2'b11 DECODE_ERROR.
interface rggen_bus_if #(
    parameter int ADDRESS_WIDTH = 16,
    parameter int BUS_WIDTH     = 32
);
    logic                     valid;
    logic [ADDRESS_WIDTH-1:0] address;
    logic                     write;
    logic [BUS_WIDTH-1:0]     write_data;
    logic [BUS_WIDTH/8-1:0]   strobe;
    logic                     ready;
    logic [1:0]               status;
    logic [BUS_WIDTH-1:0]     read_data;

    modport master (
        output valid, address, write, write_data, strobe,
        input  ready, status, read_data
    );

    modport slave (
        input  valid, address, write, write_data, strobe,
        output ready, status, read_data
    );
endinterface

// File: rtl/rggen_bus_arbiter.sv
// rggen_bus_arbiter: round-robin arbiter that shares one rggen register-block
// bus between N_MASTERS requesters. One transaction is outstanding at a time;
// the grant is held until the downstream bus completes (valid && ready) or the
// granted requester withdraws its valid.
//
// Ports:
//   i_clk, i_rst   clock, asynchronous active-high reset
//   i_valid        per-requester request valid            [N_MASTERS]
//   i_address      requester n in slice n                 [N_MASTERS*ADDRESS_WIDTH]
//   i_write        per-requester write flag               [N_MASTERS]
//   i_write_data   requester n in slice n                 [N_MASTERS*BUS_WIDTH]
//   i_strobe       requester n in slice n                 [N_MASTERS*BUS_WIDTH/8]
//   o_ready        per-requester completion pulse         [N_MASTERS]
//   o_status       rggen status, requester n in slice n   [N_MASTERS*2]
//   o_read_data    read data, requester n in slice n      [N_MASTERS*BUS_WIDTH]
//   bus_if         downstream rggen bus (master side)
module rggen_bus_arbiter #(
    parameter int N_MASTERS     = 2,
    parameter int ADDRESS_WIDTH = 16,
    parameter int BUS_WIDTH     = 32
) (
    input  logic                                 i_clk,
    input  logic                                 i_rst,
    input  logic [N_MASTERS-1:0]                 i_valid,
    input  logic [N_MASTERS*ADDRESS_WIDTH-1:0]   i_address,
    input  logic [N_MASTERS-1:0]                 i_write,
    input  logic [N_MASTERS*BUS_WIDTH-1:0]       i_write_data,
    input  logic [N_MASTERS*BUS_WIDTH/8-1:0]     i_strobe,
    output logic [N_MASTERS-1:0]                 o_ready,
    output logic [N_MASTERS*2-1:0]               o_status,
    output logic [N_MASTERS*BUS_WIDTH-1:0]       o_read_data,
    rggen_bus_if.master                          bus_if
);
    localparam int STROBE_WIDTH = BUS_WIDTH / 8;
    localparam int INDEX_WIDTH  = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;

    typedef enum logic {
        IDLE,
        BUSY
    } state_e;

    state_e                   state;
    logic [INDEX_WIDTH-1:0]   grant;
    logic [INDEX_WIDTH-1:0]   last;
    logic [INDEX_WIDTH-1:0]   next_grant;
    int                       search_index;
    logic                     found;

    logic                     grant_valid;
    logic [ADDRESS_WIDTH-1:0] mux_address;
    logic                     mux_write;
    logic [BUS_WIDTH-1:0]     mux_write_data;
    logic [STROBE_WIDTH-1:0]  mux_strobe;

    // Round-robin search starting just after the last completed requester,
    // so the requester that completed most recently has the lowest priority.
    always_comb begin
        next_grant   = last;
        found        = 1'b0;
        search_index = 0;
        for (int i = 1; i <= N_MASTERS; i++) begin
            search_index = (int'(last) + i) % N_MASTERS;
            if (!found && i_valid[search_index[INDEX_WIDTH-1:0]]) begin
                next_grant = search_index[INDEX_WIDTH-1:0];
                found      = 1'b1;
            end
        end
    end

    // Request mux toward the register block and response demux back to the
    // granted requester. Everything stays zero outside BUSY, and the
    // response only reaches a requester in a completion cycle, so a
    // downstream ready seen without valid has no effect.
    always_comb begin
        grant_valid    = 1'b0;
        mux_address    = '0;
        mux_write      = 1'b0;
        mux_write_data = '0;
        mux_strobe     = '0;
        o_ready        = '0;
        o_status       = '0;
        o_read_data    = '0;
        if (state == BUSY) begin
            for (int n = 0; n < N_MASTERS; n++) begin
                if (grant == INDEX_WIDTH'(n)) begin
                    grant_valid    = i_valid[n];
                    mux_address    = i_address[n*ADDRESS_WIDTH +: ADDRESS_WIDTH];
                    mux_write      = i_write[n];
                    mux_write_data = i_write_data[n*BUS_WIDTH +: BUS_WIDTH];
                    mux_strobe     = i_strobe[n*STROBE_WIDTH +: STROBE_WIDTH];
                    if (i_valid[n] && bus_if.ready) begin
                        o_ready[n]                           = 1'b1;
                        o_status[2*n +: 2]                   = bus_if.status;
                        o_read_data[n*BUS_WIDTH +: BUS_WIDTH] = bus_if.read_data;
                    end
                end
            end
        end
    end

    assign bus_if.valid      = grant_valid;
    assign bus_if.address    = mux_address;
    assign bus_if.write      = mux_write;
    assign bus_if.write_data = mux_write_data;
    assign bus_if.strobe     = mux_strobe;

    // Arbitration FSM. A withdrawn request (valid dropped while granted) is
    // abandoned without moving 'last', so the round-robin order is unchanged.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= IDLE;
            grant <= '0;
            last  <= INDEX_WIDTH'(N_MASTERS - 1);
        end else begin
            case (state)
                IDLE: begin
                    if (|i_valid) begin
                        grant <= next_grant;
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    if (!grant_valid) begin
                        state <= IDLE;
                    end else if (bus_if.ready) begin
                        last  <= grant;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rggen_bus_arbiter.sv
module tb_rggen_bus_arbiter;
    localparam int N  = 3;
    localparam int AW = 16;
    localparam int BW = 32;
    localparam int SW = BW / 8;

    logic            i_clk = 1'b0;
    logic            i_rst = 1'b0;
    logic [N-1:0]    i_valid;
    logic [N*AW-1:0] i_address;
    logic [N-1:0]    i_write;
    logic [N*BW-1:0] i_write_data;
    logic [N*SW-1:0] i_strobe;
    logic [N-1:0]    o_ready;
    logic [N*2-1:0]  o_status;
    logic [N*BW-1:0] o_read_data;

    rggen_bus_if #(.ADDRESS_WIDTH(AW), .BUS_WIDTH(BW)) bus_if ();

    rggen_bus_arbiter #(
        .N_MASTERS     (N),
        .ADDRESS_WIDTH (AW),
        .BUS_WIDTH     (BW)
    ) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_valid      (i_valid),
        .i_address    (i_address),
        .i_write      (i_write),
        .i_write_data (i_write_data),
        .i_strobe     (i_strobe),
        .o_ready      (o_ready),
        .o_status     (o_status),
        .o_read_data  (o_read_data),
        .bus_if       (bus_if)
    );

    always #5 i_clk = ~i_clk;

    int checks = 0;
    int passed = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic set_req(input int r, input logic [AW-1:0] a, input logic w,
                           input logic [BW-1:0] d, input logic [SW-1:0] s);
        i_address[r*AW +: AW]    = a;
        i_write[r]               = w;
        i_write_data[r*BW +: BW] = d;
        i_strobe[r*SW +: SW]     = s;
    endtask

    // Reference: first pending requester after 'lst' in cyclic order.
    function automatic int rr_pick(input int lst, input logic [N-1:0] p);
        for (int i = 1; i <= N; i++) begin
            int k;
            k = (lst + i) % N;
            if (p[k[1:0]]) return k;
        end
        return -1;
    endfunction

    // Random-phase requester state and model state
    logic [AW-1:0] ra [N];
    logic          rw [N];
    logic [BW-1:0] rdat [N];
    logic [SW-1:0] rs [N];
    logic [N-1:0]  pend;
    int            owner;
    int            mlast;
    logic          rdy;
    logic [1:0]    rstat;
    logic [BW-1:0] rrd;
    logic [N-1:0]    e_ready;
    logic [N*2-1:0]  e_status;
    logic [N*BW-1:0] e_rdata;

    initial begin
        i_valid      = '1;
        i_address    = '0;
        i_write      = '0;
        i_write_data = '0;
        i_strobe     = '0;
        set_req(0, 16'h0300, 1'b0, 32'h1111_1111, 4'hF);
        set_req(1, 16'h0010, 1'b0, 32'h2222_2222, 4'hF);
        set_req(2, 16'h0200, 1'b1, 32'h3333_3333, 4'hF);
        bus_if.ready     = 1'b0;
        bus_if.status    = 2'b00;
        bus_if.read_data = '0;

        // Reset with every requester valid
        #1 i_rst = 1'b1;
        #2;
        check("rst_o_ready",   128'(o_ready), 128'(0));
        check("rst_o_status",  128'(o_status), 128'(0));
        check("rst_o_rdata",   128'(o_read_data), 128'(0));
        check("rst_bus_valid", 128'(bus_if.valid), 128'(0));
        check("rst_bus_addr",  128'(bus_if.address), 128'(0));
        check("rst_bus_wdata", 128'(bus_if.write_data), 128'(0));
        check("rst_bus_strb",  128'(bus_if.strobe), 128'(0));
        tick();
        i_rst = 1'b0;
        tick();
        check("rel_bus_valid", 128'(bus_if.valid), 128'(1));
        check("rel_bus_addr",  128'(bus_if.address), 128'(16'h0300));
        check("rel_o_ready0",  128'(o_ready), 128'(0));
        bus_if.ready     = 1'b1;
        bus_if.read_data = 32'h1234_5678;
        #1;
        check("rel_o_ready",   128'(o_ready), 128'(3'b001));
        check("rel_o_rdata",   128'(o_read_data), 128'(96'h0000_0000_0000_0000_1234_5678));
        tick();
        i_valid = '0;
        bus_if.ready = 1'b0;
        #1;
        check("rel_idle_valid", 128'(bus_if.valid), 128'(0));

        // Single read by requester 1
        i_valid = 3'b010;
        tick();
        check("rd_bus_valid", 128'(bus_if.valid), 128'(1));
        check("rd_bus_addr",  128'(bus_if.address), 128'(16'h0010));
        check("rd_bus_write", 128'(bus_if.write), 128'(0));
        tick();
        check("rd_wait1_ready", 128'(o_ready), 128'(0));
        tick();
        check("rd_wait2_ready", 128'(o_ready), 128'(0));
        tick();
        bus_if.ready     = 1'b1;
        bus_if.status    = 2'b00;
        bus_if.read_data = 32'hA5A5_0001;
        #1;
        check("rd_o_ready",  128'(o_ready), 128'(3'b010));
        check("rd_o_rdata",  128'(o_read_data), 128'(96'h0000_0000_A5A5_0001_0000_0000));
        check("rd_o_status", 128'(o_status), 128'(0));
        tick();
        i_valid      = '0;
        bus_if.ready = 1'b0;
        #1;
        check("rd_pulse_end", 128'(o_ready), 128'(0));

        // Round-robin fairness from a fresh reset, ready held high
        i_rst = 1'b1;
        #1 i_rst = 1'b0;
        i_valid      = 3'b111;
        bus_if.ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            logic [N-1:0]    er;
            logic [N*BW-1:0] ed;
            int              who;
            if (c > 0) tick();
            bus_if.read_data = 32'h100 + c;
            #1;
            er = '0;
            ed = '0;
            if (c % 2 == 1) begin
                who = (c / 2) % 3;
                er[who] = 1'b1;
                ed[who*BW +: BW] = 32'h100 + c;
            end
            check($sformatf("rr_ready_c%0d", c), 128'(o_ready), 128'(er));
            check($sformatf("rr_rdata_c%0d", c), 128'(o_read_data), 128'(ed));
        end
        tick();
        i_valid      = '0;
        bus_if.ready = 1'b0;

        // Write routing with a slave-error response on requester 2
        set_req(0, 16'h0300, 1'b0, 32'h0BAD_0000, 4'hF);
        set_req(1, 16'h0010, 1'b1, 32'h0BAD_0001, 4'hC);
        set_req(2, 16'h0024, 1'b1, 32'hDEAD_BEEF, 4'b0011);
        i_valid = 3'b100;
        tick();
        check("wr_bus_valid", 128'(bus_if.valid), 128'(1));
        check("wr_bus_addr",  128'(bus_if.address), 128'(16'h0024));
        check("wr_bus_write", 128'(bus_if.write), 128'(1));
        check("wr_bus_wdata", 128'(bus_if.write_data), 128'(32'hDEAD_BEEF));
        check("wr_bus_strb",  128'(bus_if.strobe), 128'(4'b0011));
        bus_if.ready     = 1'b1;
        bus_if.status    = 2'b10;
        bus_if.read_data = '0;
        #1;
        check("wr_o_ready",  128'(o_ready), 128'(3'b100));
        check("wr_o_status", 128'(o_status), 128'(6'b10_00_00));
        tick();
        i_valid       = '0;
        bus_if.ready  = 1'b0;
        bus_if.status = 2'b00;
        set_req(1, 16'h0010, 1'b0, 32'h0, 4'hF);

        // Abort by requester 0 with requester 1 pending
        i_valid = 3'b011;
        tick();
        check("ab_bus_addr0", 128'(bus_if.address), 128'(16'h0300));
        tick();
        i_valid      = 3'b010;
        bus_if.ready = 1'b1;
        #1;
        check("ab_valid_fall", 128'(bus_if.valid), 128'(0));
        check("ab_no_ready",   128'(o_ready), 128'(0));
        tick();
        bus_if.ready = 1'b0;
        #1;
        check("ab_idle_valid", 128'(bus_if.valid), 128'(0));
        tick();
        check("ab_next_valid", 128'(bus_if.valid), 128'(1));
        check("ab_next_addr",  128'(bus_if.address), 128'(16'h0010));
        bus_if.ready = 1'b1;
        #1;
        check("ab_next_ready", 128'(o_ready), 128'(3'b010));
        tick();
        i_valid      = '0;
        bus_if.ready = 1'b0;

        // Abort must leave the round-robin pointer untouched
        i_valid = 3'b001;
        tick();
        check("ab2_addr0", 128'(bus_if.address), 128'(16'h0300));
        i_valid = 3'b000;
        #1;
        check("ab2_valid_fall", 128'(bus_if.valid), 128'(0));
        tick();
        i_valid = 3'b011;
        tick();
        check("ab2_regrant_addr", 128'(bus_if.address), 128'(16'h0300));
        bus_if.ready = 1'b1;
        #1;
        check("ab2_regrant_ready", 128'(o_ready), 128'(3'b001));
        tick();
        i_valid      = '0;
        bus_if.ready = 1'b0;

        // Reset while busy with ready low
        i_valid = 3'b011;
        tick();
        check("rm_busy_addr", 128'(bus_if.address), 128'(16'h0010));
        i_rst = 1'b1;
        #1;
        check("rm_valid_drop", 128'(bus_if.valid), 128'(0));
        check("rm_no_ready",   128'(o_ready), 128'(0));
        check("rm_addr_zero",  128'(bus_if.address), 128'(0));
        tick();
        check("rm_hold_ready", 128'(o_ready), 128'(0));
        i_rst = 1'b0;
        tick();
        check("rm_restart_valid", 128'(bus_if.valid), 128'(1));
        check("rm_restart_addr",  128'(bus_if.address), 128'(16'h0300));
        bus_if.ready = 1'b1;
        #1;
        check("rm_restart_ready", 128'(o_ready), 128'(3'b001));
        tick();
        i_valid      = '0;
        bus_if.ready = 1'b0;

        // Random traffic against the transaction-level model
        i_rst = 1'b1;
        #1 i_rst = 1'b0;
        pend  = '0;
        owner = -1;
        mlast = N - 1;
        for (int r = 0; r < N; r++) begin
            ra[r] = '0; rw[r] = 1'b0; rdat[r] = '0; rs[r] = '0;
        end
        for (int cyc = 0; cyc < 300; cyc++) begin
            tick();
            for (int r = 0; r < N; r++) begin
                if (!pend[r] && ($urandom_range(1, 0) == 1)) begin
                    pend[r] = 1'b1;
                    ra[r]   = AW'($urandom);
                    rw[r]   = 1'($urandom);
                    rdat[r] = $urandom;
                    rs[r]   = SW'($urandom);
                end
                i_valid[r] = pend[r];
                set_req(r, ra[r], rw[r], rdat[r], rs[r]);
            end
            rdy   = (owner >= 0) ? ($urandom_range(2, 0) == 0) : 1'($urandom);
            rstat = 2'($urandom);
            rrd   = $urandom;
            bus_if.ready     = rdy;
            bus_if.status    = rstat;
            bus_if.read_data = rrd;
            #1;
            e_ready  = '0;
            e_status = '0;
            e_rdata  = '0;
            if (owner >= 0) begin
                check("rnd_valid", 128'(bus_if.valid), 128'(1));
                check("rnd_addr",  128'(bus_if.address), 128'(ra[owner]));
                check("rnd_write", 128'(bus_if.write), 128'(rw[owner]));
                check("rnd_wdata", 128'(bus_if.write_data), 128'(rdat[owner]));
                check("rnd_strb",  128'(bus_if.strobe), 128'(rs[owner]));
                if (rdy) begin
                    e_ready[owner]            = 1'b1;
                    e_status[owner*2 +: 2]    = rstat;
                    e_rdata[owner*BW +: BW]   = rrd;
                end
            end else begin
                check("rnd_idle_valid", 128'(bus_if.valid), 128'(0));
                check("rnd_idle_addr",  128'(bus_if.address), 128'(0));
            end
            check("rnd_o_ready",  128'(o_ready), 128'(e_ready));
            check("rnd_o_status", 128'(o_status), 128'(e_status));
            check("rnd_o_rdata",  128'(o_read_data), 128'(e_rdata));
            if (owner >= 0) begin
                if (rdy) begin
                    mlast       = owner;
                    pend[owner] = 1'b0;
                    owner       = -1;
                end
            end else if (pend != '0) begin
                owner = rr_pick(mlast, pend);
            end
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/rggen_bus_arbiter.md
# rggen_bus_arbiter

- Shares one register-block bus between `N_MASTERS` requesters using round-robin arbitration.
- Each requester drives a flattened rggen bus slave port. The block drives one downstream `rggen_bus_if.master` toward the register block.
- One transaction is outstanding at a time. The grant is held until the downstream `ready`.
- It sits between multiple host bridges (e.g. APB and debug) and a single rggen register block.

## Interface
- `N_MASTERS`, 2: number of requesters; legal range 1..16.
- `ADDRESS_WIDTH`, 16: address width, same for upstream and downstream.
- `BUS_WIDTH`, 32: data width; a multiple of 8.
- `i_clk`  in  1  clock.
- `i_rst`  in  1  reset; asynchronous, active-high.
- `i_valid`  in  N_MASTERS  per-requester request valid.
- `i_address`  in  N_MASTERS*ADDRESS_WIDTH  requester n occupies slice n.
- `i_write`  in  N_MASTERS  1 = write.
- `i_write_data`  in  N_MASTERS*BUS_WIDTH  write data.
- `i_strobe`  in  N_MASTERS*BUS_WIDTH/8  byte strobes.
- `o_ready`  out  N_MASTERS  per-requester completion.
- `o_status`  out  N_MASTERS*2  `rggen_status` per requester.
- `o_read_data`  out  N_MASTERS*BUS_WIDTH  read data per requester.
- `bus_if`  `rggen_bus_if.master`  —  downstream bus (`valid`, `address`, `write`, `write_data`, `strobe` out; `ready`, `status`, `read_data` in).

## Operation
- State machine with two states: IDLE and BUSY. Registers: `state`, `grant` (index), `last` (index of the last completed grant).
- IDLE:
  - If any `i_valid` is set, pick the first set bit searching `last+1, last+2, …` with wrap modulo `N_MASTERS`.
  - Register that index in `grant` and go to BUSY.
  - No request: stay in IDLE.
- BUSY:
  - `bus_if.valid = i_valid[grant]`.
  - `address`, `write`, `write_data` and `strobe` are muxed combinationally from slice `grant`.
- Completion is `bus_if.valid && bus_if.ready` in BUSY. In that cycle:
  - `o_ready[grant] = 1`.
  - `o_status` slice `grant` = `bus_if.status`.
  - `o_read_data` slice `grant` = `bus_if.read_data`.
  - Next edge: `last <= grant`, state goes to IDLE.
- Non-granted requesters always see `o_ready = 0`, `o_status = RGGEN_OKAY` (2'b00) and `o_read_data = 0`. The same applies to every requester outside completion cycles.
- Requesters hold `valid` and payload stable until `o_ready`. If `i_valid[grant]` drops in BUSY, the transaction is abandoned:
  - `bus_if.valid` falls the same cycle.
  - The block returns to IDLE at the next edge.
  - `last` is not updated.
- Requests arriving in BUSY wait; they are never dropped.
- `N_MASTERS = 1`: the arbiter degenerates to a pass-through with the same one-cycle IDLE stage.
- Downstream `ready` seen while `bus_if.valid = 0` is ignored.

## Timing
- Reset values (immediate on `i_rst` assert, asynchronous):
  - `state = IDLE`, `grant = 0`, `last = N_MASTERS-1`, so requester 0 has first priority.
  - `bus_if.valid = 0`; `bus_if.address`, `write`, `write_data` and `strobe` = 0 while not BUSY.
  - All `o_ready = 0`, `o_status = 0`, `o_read_data = 0`.
- Latency:
  - Request seen in IDLE at cycle 0 → `bus_if.valid` in cycle 1.
  - Downstream `ready` in cycle k → `o_ready` in cycle k (combinational path).
  - IDLE in cycle k+1; a pending request reaches `bus_if.valid` in cycle k+2.
  - Minimum spacing between back-to-back transactions is 2 cycles: one idle cycle.
- Reset asserted mid-transaction: the grant is lost and no `o_ready` is produced. The requester retries after reset.
- Simultaneous requests in IDLE: the round-robin order above decides. A requester that just completed has the lowest priority next time.

## Test plan
- Reset:
  - Assert `i_rst` with all requesters valid → all outputs 0, `bus_if.valid = 0`.
  - Release → requester 0 is granted first; `bus_if.valid` is set one cycle after release.
- Single read:
  - Requester 1 reads 0x0010; downstream returns `ready` 3 cycles later with `read_data = 0xA5A5_0001` and `RGGEN_OKAY`.
  - Required: `o_ready[1]` pulses 1 cycle with that data; `o_ready[0]` stays 0.
- Round-robin fairness (N=3, all valid continuously, downstream ready on every valid):
  - Grant order 0,1,2,0,1,2.
  - Each completion is 2 cycles apart.
- Write routing:
  - Requester 2 writes address 0x0024, data 0xDEAD_BEEF, strobe 4'b0011.
  - Downstream sees exactly those values; a `RGGEN_SLAVE_ERROR` response appears only on `o_status` slice 2.
- Abort:
  - Requester 0 drops `valid` in the second BUSY cycle before `ready`.
  - Required: `bus_if.valid` falls the same cycle, IDLE next cycle, and `last` is unchanged, so requester 1 (if pending) is granted next.
- Reset mid-operation:
  - Assert `i_rst` while BUSY with downstream `ready` low.
  - Required: immediate `bus_if.valid = 0`, no `o_ready` pulse, and after release arbitration restarts at requester 0.
